// File: rtl/ror_pkg.sv
// Shared types and constants for the rotate-right operand issue queue.
package ror_pkg;

    localparam int ROR_W     = 8;
    localparam int ROR_AMT_W = 3;

    // One queued operand pair: data to rotate plus the 3-bit rotate amount.
    typedef struct packed {
        logic [ROR_W-1:0]     a;
        logic [ROR_AMT_W-1:0] b;
    } ror_entry_t;

    // Head presentation state: nothing queued, or a valid head exists.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HAVE  = 1'b1
    } head_state_t;

endpackage

// File: rtl/ror_queue_mem.sv
// Entry storage for the issue queue: one write port, one asynchronous read port.
// Contents are not reset; validity is tracked by the queue control.
module ror_queue_mem
    import ror_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  ror_entry_t      wdata,
    input  logic [AW-1:0]   raddr,
    output ror_entry_t      rdata
);

    ror_entry_t mem_array [DEPTH];

    // Write the addressed entry when a push is accepted.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[waddr] <= wdata;
        end
    end

    // Head is read combinationally so it appears the cycle after the push.
    always_comb begin
        rdata = mem_array[raddr];
    end

endmodule

// File: rtl/ror_issue_queue.sv
// Operand-pair FIFO feeding a rotate_right_8 unit; presents the oldest pair
// on out_a/out_b with a valid/ready handshake on both sides.
module ror_issue_queue
    import ror_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ROR_W-1:0]         in_a,
    input  logic [ROR_W-1:0]         in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ROR_W-1:0]         out_a,
    output logic [ROR_W-1:0]         out_b,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    head_state_t   state_q, state_d;

    logic       push;
    logic       pop;
    ror_entry_t wr_entry;
    ror_entry_t head_entry;
    logic       unused_in_b_hi;

    // Only the low amount bits are stored; the upper bits of in_b are dropped.
    assign unused_in_b_hi = ^in_b[ROR_W-1:ROR_AMT_W];

    // Handshakes depend on registered state only; flush blocks a push.
    always_comb begin
        in_ready   = (count_q < DEPTH_C);
        out_valid  = (state_q == ST_HAVE);
        push       = in_valid && in_ready && !flush;
        pop        = out_valid && out_ready && !flush;
        wr_entry.a = in_a;
        wr_entry.b = in_b[ROR_AMT_W-1:0];
    end

    // Next-state for occupancy, pointers and head state.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        state_d  = state_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = ST_EMPTY;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            case (state_q)
                ST_EMPTY: if (push) state_d = ST_HAVE;
                ST_HAVE:  if (pop && !push && (count_q == CNT_ONE)) state_d = ST_EMPTY;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Control registers; reset overrides flush, push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= ST_EMPTY;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
        end
    end

    ror_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head_entry)
    );

    // Present the head, forcing zeros whenever nothing valid is queued.
    always_comb begin
        count = count_q;
        out_a = '0;
        out_b = '0;
        if (out_valid) begin
            out_a = head_entry.a;
            out_b = {{(ROR_W-ROR_AMT_W){1'b0}}, head_entry.b};
        end
    end

endmodule
